// File: rtl/adc_sequencer_pkg.sv
// Shared ADC word layout and channel type for the sequencer and the CPU-facing FIFO word.
// Field positions must stay in step with the CPU-side C header.
package adc_sequencer_pkg;

  localparam int ADC_DATA_W        = 12;
  localparam int ADC_CHAN_W        = 5;
  localparam int ADC_WORD_W        = 32;
  localparam int ADC_WORD_OVF      = 31;
  localparam int ADC_WORD_CHAN_LSB = 16;
  localparam int ADC_WORD_DATA_LSB = 0;

  typedef logic [ADC_CHAN_W-1:0] adc_chan_t;
  typedef logic [ADC_DATA_W-1:0] adc_data_t;

  // Unused bits of the word are zero; data is zero-extended.
  function automatic logic [ADC_WORD_W-1:0] adc_pack_word(input logic      ovf,
                                                          input adc_chan_t chan,
                                                          input adc_data_t data);
    logic [ADC_WORD_W-1:0] w;
    w = '0;
    w[ADC_WORD_OVF] = ovf;
    w[ADC_WORD_CHAN_LSB +: ADC_CHAN_W] = chan;
    w[ADC_WORD_DATA_LSB +: ADC_DATA_W] = data;
    return w;
  endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Single-clock synchronous FIFO with a registered head output.
// The head register is loaded on the edge that makes an entry the head, so dout_o is valid with !empty_o.
module adc_sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] dout_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q, head_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign dout_o  = dout_q;

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    // When the slot being written becomes the head, the RAM does not hold it yet.
    head_d   = (do_push && (wr_ptr_q == rd_ptr_d)) ? din_i : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (count_d != '0) begin
        dout_q <= head_d;
      end
    end
  end

endmodule

// File: rtl/adc_sequencer.sv
// Round-robin command sequencer for the MAX10 ADC plus response router:
// audio channel goes out as a strobe, spare channels are queued for the CPU.
module adc_sequencer
  import adc_sequencer_pkg::*;
#(
  parameter int                          NUM_CHANNELS  = 4,
  parameter logic [NUM_CHANNELS*5-1:0]   CHANNEL_LIST  = {5'd4, 5'd3, 5'd2, 5'd1},
  parameter logic [4:0]                  AUDIO_CHANNEL = 5'd1,
  parameter int                          FIFO_DEPTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  command_ready_in,
  output logic [ADC_CHAN_W-1:0] command_channel_out,
  output logic                  command_startofpacket_out,
  output logic                  command_endofpacket_out,
  input  logic                  response_valid_in,
  input  logic [ADC_CHAN_W-1:0] response_channel_in,
  input  logic [ADC_DATA_W-1:0] response_data_in,
  output logic [ADC_DATA_W-1:0] audio_out,
  output logic                  audio_stb_out,
  output logic [ADC_WORD_W-1:0] adc_out,
  output logic                  adc_stb_out,
  input  logic                  adc_ack_in,
  output logic [15:0]           drop_count_out
);

  localparam int                IDX_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

  adc_chan_t             chan_tbl [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] chan_hit;

  logic [IDX_W-1:0]      idx_q, idx_d;
  adc_data_t             audio_q, audio_d;
  logic                  audio_stb_q, audio_stb_d;
  logic                  ovf_q, ovf_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;

  logic                  is_audio, is_spare, push_req;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
  logic [ADC_WORD_W-1:0] fifo_din, fifo_dout;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      assign chan_tbl[gi] = CHANNEL_LIST[gi*ADC_CHAN_W +: ADC_CHAN_W];
      assign chan_hit[gi] = (response_channel_in == chan_tbl[gi]);
    end
  endgenerate

  assign command_channel_out       = chan_tbl[idx_q];
  assign command_startofpacket_out = (idx_q == '0);
  assign command_endofpacket_out   = (idx_q == LAST_IDX);

  assign is_audio = (response_channel_in == AUDIO_CHANNEL);
  assign is_spare = (|chan_hit) & ~is_audio;
  assign push_req = response_valid_in & is_spare;

  // Full is only a drop when the consumer is not freeing a slot on the same edge.
  assign fifo_pop  = adc_ack_in & ~fifo_empty;
  assign drop      = push_req & fifo_full & ~fifo_pop;
  assign fifo_push = push_req & ~drop;
  assign fifo_din  = adc_pack_word(ovf_q, response_channel_in, response_data_in);

  always_comb begin
    idx_d = idx_q;
    if (command_ready_in) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end

    audio_d     = audio_q;
    audio_stb_d = response_valid_in & is_audio;
    if (audio_stb_d) begin
      audio_d = response_data_in;
    end

    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end else if (fifo_push) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      audio_q     <= '0;
      audio_stb_q <= 1'b0;
      ovf_q       <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      idx_q       <= idx_d;
      audio_q     <= audio_d;
      audio_stb_q <= audio_stb_d;
      ovf_q       <= ovf_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  adc_sample_fifo #(
    .WIDTH (ADC_WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .dout_o  (fifo_dout)
  );

  assign audio_out      = audio_q;
  assign audio_stb_out  = audio_stb_q;
  assign adc_out        = fifo_dout;
  assign adc_stb_out    = ~fifo_empty;
  assign drop_count_out = drop_cnt_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed bench for adc_sequencer with a scoreboard of expected FIFO words.
module tb_adc_sequencer;

  logic        clk;
  logic        rst;
  logic        command_ready_in;
  logic [4:0]  command_channel_out;
  logic        command_startofpacket_out;
  logic        command_endofpacket_out;
  logic        response_valid_in;
  logic [4:0]  response_channel_in;
  logic [11:0] response_data_in;
  logic [11:0] audio_out;
  logic        audio_stb_out;
  logic [31:0] adc_out;
  logic        adc_stb_out;
  logic        adc_ack_in;
  logic [15:0] drop_count_out;

  int          vectors = 0;
  int          miscompares = 0;

  logic [31:0] sb [$];
  int          model_count = 0;
  logic        model_ovf = 1'b0;
  logic [15:0] model_drops = 16'd0;
  logic [31:0] last_word;
  int          pops;

  adc_sequencer dut (
    .clk                       (clk),
    .rst                       (rst),
    .command_ready_in          (command_ready_in),
    .command_channel_out       (command_channel_out),
    .command_startofpacket_out (command_startofpacket_out),
    .command_endofpacket_out   (command_endofpacket_out),
    .response_valid_in         (response_valid_in),
    .response_channel_in       (response_channel_in),
    .response_data_in          (response_data_in),
    .audio_out                 (audio_out),
    .audio_stb_out             (audio_stb_out),
    .adc_out                   (adc_out),
    .adc_stb_out               (adc_stb_out),
    .adc_ack_in                (adc_ack_in),
    .drop_count_out            (drop_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic pop_head(input string tag);
    logic [31:0] exp;
    check1({tag, "_stb"}, adc_stb_out, 1'b1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, adc_out, 32'hDEAD_BEEF);
      exp = 32'hDEAD_BEEF;
    end else begin
      exp = sb.pop_front();
      check(tag, adc_out, exp);
    end
    last_word = adc_out;
    adc_ack_in = 1'b1;
    tick();
    adc_ack_in = 1'b0;
    if (model_count > 0) model_count--;
  endtask

  // Drive one spare sample; the scoreboard predicts drop/ovf behaviour.
  task automatic spare(input logic [4:0] ch, input logic [11:0] d, input logic ack);
    logic pop;
    pop = ack && (model_count > 0);
    if (pop) begin
      if (sb.size() == 0) check("sp_pop_sb_empty", adc_out, 32'hDEAD_BEEF);
      else check("sp_pop_head", adc_out, sb.pop_front());
    end
    if (model_count == 8 && !pop) begin
      model_ovf = 1'b1;
      if (model_drops != 16'hFFFF) model_drops++;
    end else begin
      sb.push_back({model_ovf, 10'b0, ch, 4'b0, d});
      model_ovf = 1'b0;
      model_count++;
    end
    if (pop) model_count--;
    response_valid_in   = 1'b1;
    response_channel_in = ch;
    response_data_in    = d;
    adc_ack_in          = ack;
    tick();
    response_valid_in = 1'b0;
    adc_ack_in        = 1'b0;
  endtask

  initial begin
    logic [4:0] exp_ch;
    rst = 1'b1;
    command_ready_in = 1'b0;
    response_valid_in = 1'b0;
    response_channel_in = 5'd0;
    response_data_in = 12'd0;
    adc_ack_in = 1'b0;
    tick();
    tick();

    check("rst_chan", {27'b0, command_channel_out}, 32'd1);
    check1("rst_sop", command_startofpacket_out, 1'b1);
    check1("rst_eop", command_endofpacket_out, 1'b0);
    check("rst_audio", {20'b0, audio_out}, 32'd0);
    check1("rst_audio_stb", audio_stb_out, 1'b0);
    check1("rst_adc_stb", adc_stb_out, 1'b0);
    check("rst_adc_out", adc_out, 32'd0);
    check("rst_drops", {16'b0, drop_count_out}, 32'd0);
    rst = 1'b0;
    tick();

    // Command round-robin
    command_ready_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_ch = 5'(k % 4 + 1);
      check("seq_chan", {27'b0, command_channel_out}, {27'b0, exp_ch});
      check1("seq_sop", command_startofpacket_out, (k % 4) == 0);
      check1("seq_eop", command_endofpacket_out, (k % 4) == 3);
      tick();
    end
    command_ready_in = 1'b0;
    check("seq_wrap", {27'b0, command_channel_out}, 32'd1);
    tick();
    check("seq_hold", {27'b0, command_channel_out}, 32'd1);

    // Audio path
    response_valid_in = 1'b1;
    response_channel_in = 5'd1;
    response_data_in = 12'hABC;
    tick();
    response_valid_in = 1'b0;
    check("aud_data", {20'b0, audio_out}, 32'h0000_0ABC);
    check1("aud_stb", audio_stb_out, 1'b1);
    check1("aud_no_fifo", adc_stb_out, 1'b0);
    tick();
    check1("aud_stb_one", audio_stb_out, 1'b0);
    check("aud_hold", {20'b0, audio_out}, 32'h0000_0ABC);

    // Unlisted channel is discarded
    response_valid_in = 1'b1;
    response_channel_in = 5'd9;
    response_data_in = 12'h555;
    tick();
    response_valid_in = 1'b0;
    check1("unl_adc_stb", adc_stb_out, 1'b0);
    check1("unl_aud_stb", audio_stb_out, 1'b0);
    check("unl_drops", {16'b0, drop_count_out}, 32'd0);

    // Ack while empty is ignored
    adc_ack_in = 1'b1;
    tick();
    adc_ack_in = 1'b0;
    check1("ack_empty", adc_stb_out, 1'b0);

    // Single spare sample with handshake
    spare(5'd3, 12'h123, 1'b0);
    check1("sp_stb", adc_stb_out, 1'b1);
    check("sp_word", adc_out, 32'h0003_0123);
    tick();
    check1("sp_stb_hold", adc_stb_out, 1'b1);
    pop_head("sp_pop");
    check1("sp_stb_fall", adc_stb_out, 1'b0);

    // Overflow: nine pushes into an eight-deep FIFO
    for (int i = 0; i < 9; i++) begin
      spare(5'(2 + i % 3), 12'(12'h100 + i), 1'b0);
    end
    check("ovf_drops", {16'b0, drop_count_out}, {16'b0, model_drops});
    check("ovf_drops_one", {16'b0, drop_count_out}, 32'd1);
    check1("ovf_stb", adc_stb_out, 1'b1);

    // Full FIFO, push with simultaneous ack: no drop
    spare(5'd2, 12'h5A5, 1'b1);
    check("fullpp_drops", {16'b0, drop_count_out}, 32'd1);

    pops = 0;
    while (sb.size() > 0 && pops < 16) begin
      if (pops < 7) check1("drain_ovf_clear", adc_out[31], 1'b0);
      pop_head("drain");
      pops++;
    end
    check("drain_count", pops, 32'd8);
    check1("drain_last_ovf", last_word[31], 1'b1);
    check("drain_last_word", last_word, 32'h8002_05A5);
    check1("drain_empty", adc_stb_out, 1'b0);

    // Reset mid-operation
    for (int i = 0; i < 5; i++) begin
      spare(5'd4, 12'(12'h200 + i), 1'b0);
    end
    command_ready_in = 1'b1;
    tick();
    tick();
    command_ready_in = 1'b0;
    check("mid_chan", {27'b0, command_channel_out}, 32'd3);
    check1("mid_stb", adc_stb_out, 1'b1);
    rst = 1'b1;
    response_valid_in = 1'b1;
    response_channel_in = 5'd4;
    response_data_in = 12'hFFF;
    tick();
    rst = 1'b0;
    response_valid_in = 1'b0;
    check1("mrst_stb", adc_stb_out, 1'b0);
    check("mrst_chan", {27'b0, command_channel_out}, 32'd1);
    check("mrst_drops", {16'b0, drop_count_out}, 32'd0);
    check1("mrst_sop", command_startofpacket_out, 1'b1);
    sb.delete();
    model_count = 0;
    model_ovf = 1'b0;
    model_drops = 16'd0;
    tick();
    check1("mrst_flushed", adc_stb_out, 1'b0);

    spare(5'd3, 12'h777, 1'b0);
    pop_head("post_rst");
    check("post_rst_word", last_word, 32'h0003_0777);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
